// File: rtl/rgb_timing_gen.sv
// rgb_timing_gen: raster sync/DE/counter generator for the RGB source path; RGB_FRAME_CNT_EN adds the Frame_Cnt output
module rgb_timing_gen #(
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_BP     = 148,
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned H_FP     = 88,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 36,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned V_FP     = 4
) (
    input  logic        Sys_Clock,
    input  logic        Reset,
    input  logic        Enable,
    output logic        HSA,
    output logic        VSA,
    output logic        DE,
    output logic [15:0] Pixel_Data_Cnt,
    output logic [15:0] Line_Data_Cnt,
    output logic        Frame_Start
`ifdef RGB_FRAME_CNT_EN
    ,
    output logic [15:0] Frame_Cnt
`endif
);
    localparam logic [15:0] H_SYNC_W = 16'(H_SYNC);
    localparam logic [15:0] H_AS     = 16'(H_SYNC + H_BP);
    localparam logic [15:0] H_AE     = 16'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [15:0] H_LAST   = 16'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [15:0] V_SYNC_W = 16'(V_SYNC);
    localparam logic [15:0] V_AS     = 16'(V_SYNC + V_BP);
    localparam logic [15:0] V_AE     = 16'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [15:0] V_LAST   = 16'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);

    logic [15:0] h_q, h_d, v_q, v_d;
    logic        hsa_q, hsa_d, vsa_q, vsa_d, de_q, de_d, fs_q, fs_d;
    logic [15:0] pix_q, pix_d, line_q, line_d;
    logic        h_last, v_last, hs, ha, vs, va, fs;

    // Decode the current raster position and form next counter and output values; Enable low zeroes everything
    always_comb begin
        h_last = h_q == H_LAST;
        v_last = v_q == V_LAST;
        hs     = h_q < H_SYNC_W;
        ha     = h_q >= H_AS && h_q < H_AE;
        vs     = v_q < V_SYNC_W;
        va     = v_q >= V_AS && v_q < V_AE;
        fs     = h_q == 16'd0 && v_q == 16'd0;
        h_d    = !Enable || h_last ? 16'd0 : h_q + 16'd1;
        v_d    = !Enable ? 16'd0 : !h_last ? v_q : v_last ? 16'd0 : v_q + 16'd1;
        hsa_d  = Enable && hs;
        vsa_d  = Enable && vs;
        de_d   = Enable && ha && va;
        fs_d   = Enable && fs;
        pix_d  = Enable && ha ? h_q - H_AS : 16'd0;
        line_d = Enable && va ? v_q - V_AS : 16'd0;
    end

    // Raster counters and registered outputs, one clock behind the counter state
    always_ff @(posedge Sys_Clock or negedge Reset) begin
        if (!Reset) begin
            h_q    <= '0;
            v_q    <= '0;
            hsa_q  <= 1'b0;
            vsa_q  <= 1'b0;
            de_q   <= 1'b0;
            fs_q   <= 1'b0;
            pix_q  <= '0;
            line_q <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            hsa_q  <= hsa_d;
            vsa_q  <= vsa_d;
            de_q   <= de_d;
            fs_q   <= fs_d;
            pix_q  <= pix_d;
            line_q <= line_d;
        end
    end

    assign HSA            = hsa_q;
    assign VSA            = vsa_q;
    assign DE             = de_q;
    assign Frame_Start    = fs_q;
    assign Pixel_Data_Cnt = pix_q;
    assign Line_Data_Cnt  = line_q;

`ifdef RGB_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Frame count steps with each Frame_Start and survives Enable low
    always_comb frame_cnt_d = fs_d ? frame_cnt_q + 16'd1 : frame_cnt_q;

    // Frame counter register, cleared only by Reset
    always_ff @(posedge Sys_Clock or negedge Reset) begin
        if (!Reset) frame_cnt_q <= '0;
        else frame_cnt_q <= frame_cnt_d;
    end

    assign Frame_Cnt = frame_cnt_q;
`endif
endmodule

// File: doc/rgb_timing_gen.md
# rgb_timing_gen

Raster timing generator for the RGB source path. It produces the horizontal/vertical sync strobes, data-enable and active-area pixel/line counters consumed by the downstream pattern stage, which fills R/G/B while DE is high. The block runs free from one system clock, and its frame geometry is set by parameters.

## Interface
Parameters:
- H_SYNC, 44: horizontal sync width, clocks (≥1)
- H_BP, 148: horizontal back porch, clocks (≥1)
- H_ACTIVE, 1920: active pixels per line (≥1)
- H_FP, 88: horizontal front porch, clocks (≥1)
- V_SYNC, 5: vertical sync width, lines (≥1)
- V_BP, 36: vertical back porch, lines (≥1)
- V_ACTIVE, 1080: active lines per frame (≥1)
- V_FP, 4: vertical front porch, lines (≥1)
- H_TOTAL and V_TOTAL are the sums of the four respective parameters; each must be ≤ 65535.

Ports:
- Sys_Clock, in, 1: system clock. All logic is on the rising edge.
- Reset, in, 1: asynchronous, active-low reset.
- Enable, in, 1: run control, sampled synchronously.
- HSA, out, 1: horizontal sync active, high during sync.
- VSA, out, 1: vertical sync active, high during sync lines.
- DE, out, 1: data enable, high in the active area.
- Pixel_Data_Cnt, out, 16: active pixel index, 0..H_ACTIVE-1.
- Line_Data_Cnt, out, 16: active line index, 0..V_ACTIVE-1.
- Frame_Start, out, 1: one-clock pulse at the first clock of each frame.
- Frame_Cnt, out, 16: frame counter. Present only with RGB_FRAME_CNT_EN.

## Operation
- Internal counters: h_cnt runs 0..H_TOTAL-1 and v_cnt runs 0..V_TOTAL-1, both 16 bit.
  - h_cnt increments every enabled clock.
  - At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt = V_TOTAL-1 coinciding with the h wrap, v_cnt wraps to 0.
- Region order within a line, starting at h_cnt = 0: sync → back porch → active → front porch. Lines within a frame use the same order.
- Decode, evaluated on the current h_cnt/v_cnt:
  - hs = h_cnt < H_SYNC
  - ha = H_SYNC+H_BP ≤ h_cnt < H_SYNC+H_BP+H_ACTIVE
  - vs and va are defined the same way using v_cnt and the V_* parameters.
- Registered outputs, updated each enabled clock:
  - HSA = hs
  - VSA = vs
  - DE = ha & va
  - Pixel_Data_Cnt = ha ? h_cnt-(H_SYNC+H_BP) : 0
  - Line_Data_Cnt = va ? v_cnt-(V_SYNC+V_BP) : 0
  - Frame_Start = (h_cnt==0 && v_cnt==0)
- Pixel_Data_Cnt and Line_Data_Cnt are zero outside their respective active windows. Line_Data_Cnt holds its value across the whole line, including porches, whenever va is true.
- Enable low, at any point including mid-frame: on the next clock, h_cnt, v_cnt and all outputs go to 0. Frame_Cnt holds its value. There is no partial-frame completion.
- Enable rising: the first enabled clock outputs the decode of (0,0): HSA=1, VSA=1, DE=0, Frame_Start=1.
- Reset assertion, asynchronous: all counters and outputs go to 0 immediately, including Frame_Cnt.
- Reset deassertion: counting begins at the first clock edge with Enable high.

## Timing
- Latency: outputs lag the counter state by exactly one clock. All outputs are mutually aligned.
- The value of every output after reset is 0.
- DE stays high for H_ACTIVE consecutive clocks per active line. Pixel_Data_Cnt increments by 1 on each of those clocks.
- Frame period is H_TOTAL×V_TOTAL clocks. Frame_Start pulses are exactly that far apart.
- HSA is high for H_SYNC clocks out of every H_TOTAL.
- VSA is high for V_SYNC×H_TOTAL clocks, starting on the same clock as Frame_Start.
- Wrap events coincide: the last clock of a frame has the h wrap and v wrap together. The next output cycle has Frame_Start=1, HSA=1 and VSA=1.
- When Enable drops and the h wrap fall on the same clock, Enable wins and the counters go to 0.

## Configuration
- Macro: RGB_FRAME_CNT_EN.
- Defined:
  - Frame_Cnt port exists.
  - Frame_Cnt increments by 1 on the same clock as each Frame_Start pulse; the first frame after reset reads 1.
  - Frame_Cnt wraps from 65535 to 0.
  - Frame_Cnt is cleared only by Reset.
- Undefined: no Frame_Cnt port and no frame counter logic. All other behaviour is identical.

## Test plan
Small geometry used by all scenarios: H=2/3/8/2 (H_TOTAL 15), V=1/2/4/1 (V_TOTAL 8).
- Reset low, then released with Enable=1 → all outputs 0 during reset. On the first enabled clock, HSA=1, VSA=1, Frame_Start=1 and DE=0.
- Run one line → HSA high for 2 clocks. On the active line (v=3), DE is high on clocks 5..12 with Pixel_Data_Cnt 0..7, then returns to 0.
- Run two full frames → Frame_Start pulses 120 clocks apart. DE is high for 32 clocks per frame, and Line_Data_Cnt takes the values 0,1,2,3 across the active lines.
- Drop Enable at h=7, v=4 → next clock all outputs are 0. Re-assert Enable → sequence restarts with Frame_Start=1.
- Assert Reset asynchronously mid-line, between edges → outputs are 0 before the next clock edge.
- With RGB_FRAME_CNT_EN defined: Frame_Cnt reads 1, 2, 3 on successive Frame_Start pulses, and holds its value while Enable is low. A forced preload of 65535 wraps to 0 at the next Frame_Start.
